// File: rtl/seq_mult_4x4_pkg.sv
// Shared types and sizes for the 4x4 sequential shift-add multiplier.
// Only W = 4 is supported; the product is always 2*W bits wide.
package seq_mult_4x4_pkg;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_4x4_adder.sv
// N-bit ripple-carry adder built from full-adder cells; purely combinational.
// The carry-out is returned as the top bit of the (N+1)-bit sum.
module ripple_adder_w #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N:0]   sum
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign sum[N] = carry[N];

endmodule

// File: rtl/seq_mult_4x4.sv
// Sequential shift-add multiplier: one operand pair at a time, W add/shift
// steps, result held in DONE until the downstream handshake.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   RUN   | one add/shift step per cycle, counter tracks the step
//   DONE  | product valid and held until out_ready
module seq_mult_4x4 #(
  parameter int W = seq_mult_4x4_pkg::W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  import seq_mult_4x4_pkg::*;

  localparam int CW = $clog2(W);

  state_t         state;
  state_t         state_nxt;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mcand;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   addend;
  logic [W:0]     sum;
  logic           last_step;

  assign last_step = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // Add the multiplicand into the upper half only when the current multiplier LSB is set.
  assign addend = acc[0] ? mcand : '0;

  ripple_adder_w #(.N(W)) u_adder (
    .x   (acc[2*W-1:W]),
    .y   (addend),
    .cin (1'b0),
    .sum (sum)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            acc   <= {{W{1'b0}}, b};
            cnt   <= '0;
          end
        end
        RUN: begin
          // Carry, partial sum and remaining multiplier bits shift right together.
          acc <= {sum, acc[W-1:1]};
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_seq_mult_4x4.sv
// Self-checking bench for seq_mult_4x4: directed cases, random ops with
// noise on ignored inputs, mid-RUN reset, and a back-to-back exhaustive sweep.
module tb_seq_mult_4x4;

  logic       clk;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seq_mult_4x4 dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mult(input logic [3:0] x, input logic [3:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  // One full transaction. Latency counts edges including the accept edge:
  // accept (IDLE->RUN) plus 4 RUN steps puts out_valid high after the 5th.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        input int hold, input bit noise);
    int n;
    logic [7:0] exp;
    exp = ref_mult(av, bv);
    wait_ready();
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = 1'b0;
    tick();
    chk("busy_after_accept", busy, 1);
    chk("in_ready_in_run", in_ready, 0);
    n = 1;
    while (!out_valid && n < 20) begin
      if (noise) begin
        in_valid  = 1'($urandom);
        a         = 4'($urandom);
        b         = 4'($urandom);
        out_ready = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("latency_edges", n, 5);
    chk("product", product, exp);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        a        = 4'($urandom);
        b        = 4'($urandom);
      end
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_product", product, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("drop_valid", out_valid, 0);
    chk("ready_after_done", in_ready, 1);
    chk("busy_after_done", busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    resetn    = 1'b0;
    in_valid  = 1'b1;
    a         = 4'hA;
    b         = 4'h5;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    resetn    = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);

    run_op(4'd5, 4'd3, 0, 1'b0);
    chk("p_5x3", product, 8'h0F);
    run_op(4'd15, 4'd15, 0, 1'b0);
    run_op(4'd0, 4'd9, 0, 1'b0);
    run_op(4'd8, 4'd1, 0, 1'b0);
    run_op(4'd7, 4'd6, 10, 1'b0);
    run_op(4'd4, 4'd5, 2, 1'b1);

    // Noise during RUN: a=3,b=3 with in_valid high must not disturb the result.
    wait_ready();
    in_valid = 1'b1; a = 4'd6; b = 4'd7;
    tick();
    in_valid = 1'b1; a = 4'd3; b = 4'd3;
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    in_valid = 1'b0;
    chk("ignore_latency", n, 5);
    chk("ignore_product", product, ref_mult(4'd6, 4'd7));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ignore_drop", out_valid, 0);

    // Reset during the 2nd RUN cycle, with out_ready high.
    wait_ready();
    in_valid = 1'b1; a = 4'd11; b = 4'd13; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("midrun_rst_ready", in_ready, 1);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_product", product, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrun_no_valid", seen, 0);
    out_ready = 1'b0;
    run_op(4'd2, 4'd9, 0, 1'b0);

    for (int i = 0; i < 30; i++)
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(3, 0)), 1'b1);

    // Back-to-back exhaustive sweep with in_valid and out_ready held high.
    wait_ready();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      a = pair[7:4];
      b = pair[3:0];
      chk("b2b_ready", in_ready, 1);
      tick();
      chk("b2b_accept", busy, 1);
      n = 1;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("b2b_latency", n, 5);
      chk("b2b_product", product, ref_mult(pair[7:4], pair[3:0]));
      tick();
      chk("b2b_drop", out_valid, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
